vram_port_arbiter: RTL

- Shares one VRAM bank read/write port among three requesters: BG fetch (bg_processing_circuit), OBJ fetch (obj_top) and CPU bus.
- Sits between the fetch engines and a VRAM bank. Per cycle it picks one requester, registers the address/write onto the bank port, and returns read data tagged to the winner after a fixed latency.
- A starvation counter guarantees CPU forward progress during active display.

---
 rtl/vram_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one VRAM bank port among BG, OBJ and CPU with a CPU starvation guard; define VRAM_ARB_STATS_EN for the conflict counter
module vram_port_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int READ_LAT     = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              rst_b,
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  input  logic              obj_req,
  input  logic [ADDR_W-1:0] obj_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              bg_gnt,
  output logic              obj_gnt,
  output logic              cpu_gnt,
  output logic              bg_valid,
  output logic              obj_valid,
  output logic              cpu_valid,
  output logic [31:0]       rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       stat_conflicts
);
  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_BG   = 2'd1;
  localparam logic [1:0] ID_OBJ  = 2'd2;
  localparam logic [1:0] ID_CPU  = 2'd3;
  localparam logic [7:0] LIMIT   = 8'(STARVE_LIMIT);
  localparam int         TW      = 2 * (READ_LAT + 1);

  logic              force_cpu;
  logic [1:0]        win_id;
  logic [ADDR_W-1:0] win_addr;
  logic [1:0]        cap_id;
  logic [1:0]        end_id;
  logic [7:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [TW-1:0]     tag_q, tag_d;
  logic [READ_LAT-1:0] wr_q, wr_d;
  logic [31:0]       rd_data_q, rd_data_d;

  // Arbitration: a starved CPU overrides, otherwise fixed priority bg > obj > cpu; nothing is granted in reset
  always_comb begin
    force_cpu = cpu_req && (starve_q == LIMIT);
    bg_gnt    = rst_b && bg_req && !force_cpu;
    obj_gnt   = rst_b && obj_req && !bg_req && !force_cpu;
    cpu_gnt   = rst_b && cpu_req && (force_cpu || (!bg_req && !obj_req));
    win_id    = bg_gnt ? ID_BG : obj_gnt ? ID_OBJ : cpu_gnt ? ID_CPU : ID_NONE;
    win_addr  = bg_gnt ? bg_addr : obj_gnt ? obj_addr : cpu_addr;
  end

  // Next state: bank port load, tag/write-flag shift, read data capture one stage before the response end
  always_comb begin
    starve_d    = (!cpu_req || cpu_gnt) ? 8'd0 : (starve_q == LIMIT) ? LIMIT : starve_q + 8'd1;
    mem_addr_d  = (win_id != ID_NONE) ? win_addr : mem_addr_q;
    mem_we_d    = cpu_gnt && cpu_we;
    mem_wdata_d = mem_we_d ? cpu_wdata : mem_wdata_q;
    tag_d       = TW'({tag_q, win_id});
    wr_d        = READ_LAT'({wr_q, mem_we_d});
    cap_id      = tag_q[TW-3 -: 2];
    end_id      = tag_q[TW-1 -: 2];
    rd_data_d   = (cap_id != ID_NONE && !wr_q[READ_LAT-1]) ? mem_rdata : rd_data_q;
  end

  // State registers; reset discards every in-flight tag
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      tag_q       <= '0;
      wr_q        <= '0;
      rd_data_q   <= '0;
    end else begin
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      tag_q       <= tag_d;
      wr_q        <= wr_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_data   = rd_data_q;
  assign bg_valid  = end_id == ID_BG;
  assign obj_valid = end_id == ID_OBJ;
  assign cpu_valid = end_id == ID_CPU;

`ifdef VRAM_ARB_STATS_EN
  logic        conflict;
  logic [15:0] stat_q, stat_d;

  // Saturating count of cycles with two or more requesters pending
  always_comb begin
    conflict = (bg_req && obj_req) || (bg_req && cpu_req) || (obj_req && cpu_req);
    stat_d   = (conflict && stat_q != 16'hFFFF) ? stat_q + 16'd1 : stat_q;
  end

  // Conflict counter register, cleared only by reset
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_conflicts = stat_q;
`else
  assign stat_conflicts = '0;
`endif
endmodule
